// File: rtl/uart_top.sv
// -----------------------------------------------------------------------------
// uart_top : 8N1 UART transmitter with an internal loopback receiver.
//
// The transmitter serialises a byte LSB first between a start bit (0) and a
// stop bit (1), each bit lasting CLKS_PER_BIT = CLK_FREQ/BAUD_RATE clocks.
// The receiver listens to the transmitter's own line register and reports
// every correctly framed byte.
//
// Optional feature macro: UART_TOP_PARITY_EN
//   When defined, an even-parity bit is inserted after the data bits
//   (11-bit frame) and the receiver drops frames whose parity does not match.
//
// Ports:
//   clk       in   1  single clock, all logic on the rising edge
//   rst       in   1  synchronous active-low reset
//   tx_start  in   1  request to send tx_data (ignored while busy or in reset)
//   tx_data   in   8  byte to send, captured when the request is accepted
//   tx        out  1  serial line, idle high, registered
//   tx_busy   out  1  high while a frame is in progress
//   rx_data   out  8  last byte received by the loopback receiver
//   rx_done   out  1  one-cycle pulse when a valid byte has been received
// -----------------------------------------------------------------------------
module uart_top #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The receiver reaches the start-bit centre one count early because the
  // edge detector itself costs a cycle.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TOP_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_TOP_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rxState_e;

  txState_e         txStateQ, txStateD;
  logic [CNT_W-1:0] txCntQ, txCntD;
  logic [2:0]       txBitQ, txBitD;
  logic [7:0]       txByteQ, txByteD;
  logic             txLineQ, txLineD;
  logic             txBusyQ, txBusyD;

  rxState_e         rxStateQ, rxStateD;
  logic [CNT_W-1:0] rxCntQ, rxCntD;
  logic [2:0]       rxBitQ, rxBitD;
  logic [7:0]       rxShiftQ, rxShiftD;
  logic             rxPrevQ;
  logic [7:0]       rxDataQ, rxDataD;
  logic             rxDoneQ, rxDoneD;
  logic             rxIn;
`ifdef UART_TOP_PARITY_EN
  logic             rxParOkQ, rxParOkD;
`endif

  assign rxIn    = txLineQ;
  assign tx      = txLineQ;
  assign tx_busy = txBusyQ;
  assign rx_data = rxDataQ;
  assign rx_done = rxDoneQ;

  // TX state register; line and busy are registered from next-state values
  always_ff @(posedge clk) begin
    if (!rst) begin
      txStateQ <= TX_IDLE;
      txCntQ   <= '0;
      txBitQ   <= '0;
      txByteQ  <= '0;
      txLineQ  <= 1'b1;
      txBusyQ  <= 1'b0;
    end else begin
      txStateQ <= txStateD;
      txCntQ   <= txCntD;
      txBitQ   <= txBitD;
      txByteQ  <= txByteD;
      txLineQ  <= txLineD;
      txBusyQ  <= txBusyD;
    end
  end

  // TX next state: a request is only seen in IDLE, so the byte is frozen
  always_comb begin
    txStateD = txStateQ;
    txCntD   = txCntQ;
    txBitD   = txBitQ;
    txByteD  = txByteQ;
    case (txStateQ)
      TX_IDLE: begin
        if (tx_start) begin
          txStateD = TX_START;
          txByteD  = tx_data;
          txCntD   = '0;
        end
      end
      TX_START: begin
        if (txCntQ == CNT_LAST) begin
          txCntD   = '0;
          txStateD = TX_DATA;
        end else begin
          txCntD = txCntQ + 1'b1;
        end
      end
      TX_DATA: begin
        if (txCntQ == CNT_LAST) begin
          txCntD = '0;
          if (txBitQ == 3'd7) begin
            txBitD = '0;
`ifdef UART_TOP_PARITY_EN
            txStateD = TX_PARITY;
`else
            txStateD = TX_STOP;
`endif
          end else begin
            txBitD = txBitQ + 3'd1;
          end
        end else begin
          txCntD = txCntQ + 1'b1;
        end
      end
`ifdef UART_TOP_PARITY_EN
      TX_PARITY: begin
        if (txCntQ == CNT_LAST) begin
          txCntD   = '0;
          txStateD = TX_STOP;
        end else begin
          txCntD = txCntQ + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (txCntQ == CNT_LAST) begin
          txCntD   = '0;
          txStateD = TX_IDLE;
        end else begin
          txCntD = txCntQ + 1'b1;
        end
      end
      default: txStateD = TX_IDLE;
    endcase
  end

  // TX outputs decoded from the next state so they change on the same edge
  always_comb begin
    txBusyD = (txStateD != TX_IDLE);
    case (txStateD)
      TX_START:  txLineD = 1'b0;
      TX_DATA:   txLineD = txByteD[txBitD];
`ifdef UART_TOP_PARITY_EN
      TX_PARITY: txLineD = ^txByteD;
`endif
      default:   txLineD = 1'b1;
    endcase
  end

  // RX state register and output holding registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxStateQ <= RX_IDLE;
      rxCntQ   <= '0;
      rxBitQ   <= '0;
      rxShiftQ <= '0;
      rxPrevQ  <= 1'b1;
      rxDataQ  <= 8'h00;
      rxDoneQ  <= 1'b0;
`ifdef UART_TOP_PARITY_EN
      rxParOkQ <= 1'b0;
`endif
    end else begin
      rxStateQ <= rxStateD;
      rxCntQ   <= rxCntD;
      rxBitQ   <= rxBitD;
      rxShiftQ <= rxShiftD;
      rxPrevQ  <= rxIn;
      rxDataQ  <= rxDataD;
      rxDoneQ  <= rxDoneD;
`ifdef UART_TOP_PARITY_EN
      rxParOkQ <= rxParOkD;
`endif
    end
  end

  // RX next state: half-bit check of the start bit, then full-bit hops
  always_comb begin
    rxStateD = rxStateQ;
    rxCntD   = rxCntQ;
    rxBitD   = rxBitQ;
    rxShiftD = rxShiftQ;
`ifdef UART_TOP_PARITY_EN
    rxParOkD = rxParOkQ;
`endif
    case (rxStateQ)
      RX_IDLE: begin
        if (rxPrevQ && !rxIn) begin
          rxStateD = RX_START;
          rxCntD   = '0;
        end
      end
      RX_START: begin
        if (rxCntQ == CNT_HALF) begin
          rxCntD   = '0;
          rxBitD   = '0;
          rxStateD = rxIn ? RX_IDLE : RX_DATA;
        end else begin
          rxCntD = rxCntQ + 1'b1;
        end
      end
      RX_DATA: begin
        if (rxCntQ == CNT_LAST) begin
          rxCntD   = '0;
          rxShiftD = {rxIn, rxShiftQ[7:1]};
          if (rxBitQ == 3'd7) begin
            rxBitD = '0;
`ifdef UART_TOP_PARITY_EN
            rxStateD = RX_PARITY;
`else
            rxStateD = RX_STOP;
`endif
          end else begin
            rxBitD = rxBitQ + 3'd1;
          end
        end else begin
          rxCntD = rxCntQ + 1'b1;
        end
      end
`ifdef UART_TOP_PARITY_EN
      RX_PARITY: begin
        if (rxCntQ == CNT_LAST) begin
          rxCntD   = '0;
          rxParOkD = (rxIn == ^rxShiftQ);
          rxStateD = RX_STOP;
        end else begin
          rxCntD = rxCntQ + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rxCntQ == CNT_LAST) begin
          rxCntD   = '0;
          rxStateD = RX_IDLE;
        end else begin
          rxCntD = rxCntQ + 1'b1;
        end
      end
      default: rxStateD = RX_IDLE;
    endcase
  end

  // RX outputs: a byte is committed only when the stop-bit centre reads high
  always_comb begin
    rxDoneD = (rxStateQ == RX_STOP) && (rxCntQ == CNT_LAST) && rxIn;
`ifdef UART_TOP_PARITY_EN
    rxDoneD = rxDoneD && rxParOkQ;
`endif
    rxDataD = rxDoneD ? rxShiftQ : rxDataQ;
  end

endmodule

// File: tb/tb_uart_top.sv
// -----------------------------------------------------------------------------
// tb_uart_top : table-driven bench for uart_top at default parameters.
// Each table entry is sent back-to-back; the line is sampled at every bit
// centre and compared with a hand-written frame image, along with busy
// length, rx_done pulse shape and received byte. Reset-related corners are
// hand-written sequences. Define UART_TOP_PARITY_EN to check 11-bit frames.
// -----------------------------------------------------------------------------
module tb_uart_top;

  localparam int CPB = 434;
`ifdef UART_TOP_PARITY_EN
  localparam int FRAME_BITS   = 11;
  localparam int FRAME_CYCLES = 4774;
`else
  localparam int FRAME_BITS   = 10;
  localparam int FRAME_CYCLES = 4340;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txLine;
  logic       txBusy;
  logic [7:0] rxData;
  logic       rxDone;

  int total = 0;
  int bad   = 0;

  uart_top dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (txStart),
    .tx_data  (txData),
    .tx       (txLine),
    .tx_busy  (txBusy),
    .rx_data  (rxData),
    .rx_done  (rxDone)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    logic [7:0]  rxExp;
    int          injectAt;
  } vec_t;

  vec_t vecs[6];

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Sends one byte and records the line at each bit centre until busy drops
  task automatic applyStimulus(input logic [7:0] data, input int injectAt,
                               output logic [10:0] lineBits,
                               output int busyCycles, output int donePulses,
                               output int doneHigh);
    logic prevDone;
    txData  = data;
    txStart = 1'b1;
    @(posedge clk);
    #1;
    txStart = 1'b0;
    txData  = ~data;
    checkOutput("accept_tx", 32'(txLine), 32'd0);
    checkOutput("accept_busy", 32'(txBusy), 32'd1);
    lineBits   = '0;
    busyCycles = -1;
    donePulses = 0;
    doneHigh   = 0;
    prevDone   = 1'b0;
    for (int c = 1; c <= FRAME_CYCLES + 50; c++) begin
      if (c == injectAt) begin
        txStart = 1'b1;
        txData  = 8'hFF;
      end
      @(posedge clk);
      #1;
      txStart = 1'b0;
      for (int k = 0; k < FRAME_BITS; k++) begin
        if (c == k * CPB + CPB / 2) lineBits[k] = txLine;
      end
      if (rxDone) begin
        doneHigh++;
        if (!prevDone) donePulses++;
      end
      prevDone = rxDone;
      if (!txBusy) begin
        busyCycles = c;
        break;
      end
    end
  endtask

  initial begin
    logic [10:0] lineBits;
    int busyCycles, donePulses, doneHigh, rxSeen;

`ifdef UART_TOP_PARITY_EN
    vecs[0] = '{8'h55, 11'h4AA, 8'h55, -1};
    vecs[1] = '{8'hA3, 11'h546, 8'hA3, -1};
    vecs[2] = '{8'h0F, 11'h41E, 8'h0F, 1000};
    vecs[3] = '{8'h01, 11'h602, 8'h01, -1};
    vecs[4] = '{8'hFF, 11'h5FE, 8'hFF, -1};
    vecs[5] = '{8'h00, 11'h400, 8'h00, -1};
`else
    vecs[0] = '{8'h55, 11'h2AA, 8'h55, -1};
    vecs[1] = '{8'hA3, 11'h346, 8'hA3, -1};
    vecs[2] = '{8'h0F, 11'h21E, 8'h0F, 1000};
    vecs[3] = '{8'h01, 11'h202, 8'h01, -1};
    vecs[4] = '{8'hFF, 11'h3FE, 8'hFF, -1};
    vecs[5] = '{8'h00, 11'h200, 8'h00, -1};
`endif

    // Reset with a request held high: the request must be ignored
    rst     = 1'b0;
    txStart = 1'b1;
    txData  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx", 32'(txLine), 32'd1);
    checkOutput("rst_busy", 32'(txBusy), 32'd0);
    checkOutput("rst_done", 32'(rxDone), 32'd0);
    checkOutput("rst_rxdata", 32'(rxData), 32'h00);
    txStart = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(txBusy), 32'd0);

    // Table frames run back-to-back; entry 2 gets a mid-frame request
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].injectAt, lineBits, busyCycles,
                    donePulses, doneHigh);
      for (int k = 0; k < FRAME_BITS; k++) begin
        checkOutput($sformatf("v%0d_bit%0d", i, k), 32'(lineBits[k]),
                    32'(vecs[i].frame[k]));
      end
      checkOutput($sformatf("v%0d_busylen", i), 32'(busyCycles),
                  32'(FRAME_CYCLES));
      checkOutput($sformatf("v%0d_pulses", i), 32'(donePulses), 32'd1);
      checkOutput($sformatf("v%0d_pulsewidth", i), 32'(doneHigh), 32'd1);
      checkOutput($sformatf("v%0d_rxdata", i), 32'(rxData),
                  32'(vecs[i].rxExp));
    end

    // Reset during the data bits of 8'hA3 must abort cleanly
    @(posedge clk);
    #1;
    txData  = 8'hA3;
    txStart = 1'b1;
    @(posedge clk);
    #1;
    txStart = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    checkOutput("mid_busy_before", 32'(txBusy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_tx", 32'(txLine), 32'd1);
    checkOutput("mid_busy", 32'(txBusy), 32'd0);
    checkOutput("mid_rxdata", 32'(rxData), 32'h00);
    rst    = 1'b1;
    rxSeen = 0;
    repeat (FRAME_CYCLES + 500) begin
      @(posedge clk);
      #1;
      if (rxDone) rxSeen++;
    end
    checkOutput("mid_no_done", 32'(rxSeen), 32'd0);
    checkOutput("mid_idle_tx", 32'(txLine), 32'd1);

    // Recovery: a normal frame after the aborted one
    applyStimulus(8'h3C, -1, lineBits, busyCycles, donePulses, doneHigh);
    checkOutput("post_busylen", 32'(busyCycles), 32'(FRAME_CYCLES));
    checkOutput("post_pulses", 32'(donePulses), 32'd1);
    checkOutput("post_rxdata", 32'(rxData), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; default 434).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port tx_start  input  1  request to send tx_data, sampled on the rising edge.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, captured when the request is accepted.
REQ-007 SHALL have port tx  output  1  serial line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port rx_data  output  8  last byte received by the internal loopback receiver.
REQ-010 SHALL have port rx_done  output  1  one-cycle pulse when a valid byte has been received.

Function
REQ-011 TX FSM SHALL have states IDLE, START, DATA, PARITY (only with REQ-030), and STOP.
REQ-012 In IDLE with tx_start=1 at a rising edge, the block SHALL latch tx_data, enter START, and set tx_busy=1 and tx=0 on that same edge.
REQ-013 Each bit SHALL last exactly CLKS_PER_BIT cycles, with a bit-cycle counter running 0..CLKS_PER_BIT-1.
REQ-014 DATA SHALL send 8 bits LSB first, and the bit index SHALL wrap 7->0 on exit.
REQ-015 STOP SHALL drive tx=1 for one bit time, then return to IDLE with tx_busy=0 on the edge that ends the stop bit.
REQ-016 A frame without parity SHALL be 10 bits, i.e. 10*CLKS_PER_BIT cycles from acceptance to tx_busy falling.
REQ-017 tx_start SHALL be ignored while tx_busy=1; the latched byte SHALL NOT change mid-frame.
REQ-018 A new tx_start SHALL be accepted in the first cycle after tx_busy falls (back-to-back frames, no gap bit required).
REQ-019 tx SHALL be driven from a register (glitch-free).
REQ-020 The internal receiver SHALL take its input from the internal tx signal (loopback).
REQ-021 The receiver SHALL detect a falling edge, recheck low at mid start bit (CLKS_PER_BIT/2), and otherwise return to idle as a false start.
REQ-022 The receiver SHALL sample each data bit and the stop bit at bit centres.
REQ-023 If the stop bit is 1, the receiver SHALL update rx_data and pulse rx_done high for exactly one cycle.
REQ-024 If the stop bit is 0 (framing error), the receiver SHALL leave rx_data unchanged, emit no rx_done, and return to idle.
REQ-025 rx_data SHALL hold its value until the next valid frame.

Reset
REQ-026 rst=0 at a rising edge SHALL force tx=1, tx_busy=0, rx_data=8'h00, rx_done=0, both FSMs to idle, and all counters to 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately; no partial rx_done SHALL follow.
REQ-028 tx_start SHALL be ignored in any cycle where rst=0.
REQ-029 Normal operation SHALL start on the first rising edge with rst=1.

Configuration
REQ-030 With macro UART_TOP_PARITY_EN defined, an even-parity bit SHALL follow the data bits and the frame SHALL be 11 bits.
REQ-031 With UART_TOP_PARITY_EN defined, a receiver parity mismatch SHALL suppress rx_done and leave rx_data unchanged.
REQ-032 Without UART_TOP_PARITY_EN, there SHALL be no PARITY state or logic and the frame SHALL be 10 bits.

Verification
REQ-033 Reset: hold rst=0 for 3 cycles -> tx=1, tx_busy=0, rx_done=0, rx_data=8'h00.
REQ-034 Single frame: send 8'h55 with defaults -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles; tx_busy high for 4340 cycles; one rx_done pulse with rx_data=8'h55.
REQ-035 Back-to-back: send 8'h55, then 8'hA3 in the cycle after tx_busy falls -> two correct frames, and rx_data ends at 8'hA3 after two rx_done pulses.
REQ-036 Busy ignore: pulse tx_start with tx_data=8'hFF mid-frame of 8'h0F -> only 8'h0F is sent and tx_busy duration is unchanged.
REQ-037 Reset mid-frame: assert rst=0 during DATA of 8'hA3 -> tx=1 and tx_busy=0 the next cycle, with no rx_done.
REQ-038 Parity (UART_TOP_PARITY_EN defined): send 8'hA3 -> parity bit 0, 11-bit frame of 4774 cycles, rx_data=8'hA3.
